// File: rtl/eq_param_ctrl_if.sv
// Front-panel bus for eq_param_ctrl: raw keys, mode/enable, frame strobe and committed coefficients.
// master = panel/driver side, slave = controller side.
interface eq_param_ctrl_if;
  logic       iINC_KEY_N;
  logic       iDEC_KEY_N;
  logic       iSEL_C;
  logic       iEN;
  logic       iFRAME_END;
  logic [7:0] oCONST_K;
  logic [7:0] oCONST_C;
  logic       oPENDING;
  logic       oUPDATE;

  modport master (
    output iINC_KEY_N, iDEC_KEY_N, iSEL_C, iEN, iFRAME_END,
    input  oCONST_K, oCONST_C, oPENDING, oUPDATE
  );

  modport slave (
    input  iINC_KEY_N, iDEC_KEY_N, iSEL_C, iEN, iFRAME_END,
    output oCONST_K, oCONST_C, oPENDING, oUPDATE
  );
endinterface

// File: rtl/eq_param_ctrl.sv
// eq_param_ctrl: key synchronizer/debouncer, single-owner key arbiter, saturating K/C stepper
// with frame-boundary commit of the staged coefficients.
// Optional feature macro: EQ_PARAM_CTRL_AUTOREPEAT_EN (adds HELD->REPEAT auto-repeat).
module eq_param_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter logic [7:0]  K_RESET         = 8'd1,
  parameter logic [7:0]  C_RESET         = 8'd0
) (
  input  logic            iCLK,
  input  logic            iRST,
  eq_param_ctrl_if.slave  bus
);

  // One interval counter is shared by all states; it is sized for the longest interval.
  localparam int unsigned MAX_A  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_B  = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
  localparam int unsigned CNT_W  = (MAX_B < 2) ? 1 : $clog2(MAX_B + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef EQ_PARAM_CTRL_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);
`endif
  localparam logic [7:0] K_MIN = 8'd1;
  localparam logic [7:0] V_MAX = 8'd255;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DEBOUNCE = 3'd1,
    S_HELD     = 3'd2,
    S_RELEASE  = 3'd3
`ifdef EQ_PARAM_CTRL_AUTOREPEAT_EN
    ,S_REPEAT  = 3'd4
`endif
  } state_t;

  logic [1:0]       r_inc_sync, r_dec_sync;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_owner, w_owner_nxt;   // 0 = INC owns the FSM, 1 = DEC
  logic             w_step;
  logic             w_inc_p, w_dec_p, w_own_p, w_oth_p;

  logic [7:0] r_stg_k, r_stg_c, r_const_k, r_const_c;
  logic [7:0] w_stg_k_nxt, w_stg_c_nxt, w_const_k_nxt, w_const_c_nxt;
  logic       r_pending, r_update, w_pending_nxt, w_update_nxt;

  // Two-flop synchronizers; released (high) is the reset level.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_inc_sync <= 2'b11;
      r_dec_sync <= 2'b11;
    end else begin
      r_inc_sync <= {r_inc_sync[0], bus.iINC_KEY_N};
      r_dec_sync <= {r_dec_sync[0], bus.iDEC_KEY_N};
    end
  end

  assign w_inc_p = ~r_inc_sync[1];
  assign w_dec_p = ~r_dec_sync[1];
  assign w_own_p = r_owner ? w_dec_p : w_inc_p;
  assign w_oth_p = r_owner ? w_inc_p : w_dec_p;

  // FSM state, interval counter and owner registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_owner <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // Arbitration / debounce next-state logic; w_step marks an accepted step.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_owner_nxt = r_owner;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_inc_p ^ w_dec_p) begin
          w_owner_nxt = w_dec_p;
          w_state_nxt = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (!w_own_p || w_oth_p) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = S_HELD;
          w_cnt_nxt   = '0;
          w_step      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_HELD: begin
        if (!w_own_p) begin
          w_state_nxt = S_RELEASE;
          w_cnt_nxt   = '0;
        end
`ifdef EQ_PARAM_CTRL_AUTOREPEAT_EN
        else if (r_cnt == RD_LAST) begin
          w_state_nxt = S_REPEAT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
`endif
      end
`ifdef EQ_PARAM_CTRL_AUTOREPEAT_EN
      S_REPEAT: begin
        if (!w_own_p) begin
          w_state_nxt = S_RELEASE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == RR_LAST) begin
          w_cnt_nxt = '0;
          w_step    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
`endif
      S_RELEASE: begin
        if (w_inc_p || w_dec_p) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Saturating step on the staged registers, frame commit from the pre-step staged values.
  always_comb begin
    w_stg_k_nxt = r_stg_k;
    w_stg_c_nxt = r_stg_c;
    if (w_step && bus.iEN) begin
      if (bus.iSEL_C) begin
        if (r_owner) begin
          if (r_stg_c != 8'd0) w_stg_c_nxt = r_stg_c - 8'd1;
        end else begin
          if (r_stg_c != V_MAX) w_stg_c_nxt = r_stg_c + 8'd1;
        end
      end else begin
        if (r_owner) begin
          if (r_stg_k > K_MIN) w_stg_k_nxt = r_stg_k - 8'd1;
        end else begin
          if (r_stg_k != V_MAX) w_stg_k_nxt = r_stg_k + 8'd1;
        end
      end
    end
    w_const_k_nxt = bus.iFRAME_END ? r_stg_k : r_const_k;
    w_const_c_nxt = bus.iFRAME_END ? r_stg_c : r_const_c;
    w_update_nxt  = bus.iFRAME_END && ((r_stg_k != r_const_k) || (r_stg_c != r_const_c));
    w_pending_nxt = (w_stg_k_nxt != w_const_k_nxt) || (w_stg_c_nxt != w_const_c_nxt);
  end

  // Staged/committed coefficient and status registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_stg_k   <= K_RESET;
      r_stg_c   <= C_RESET;
      r_const_k <= K_RESET;
      r_const_c <= C_RESET;
      r_pending <= 1'b0;
      r_update  <= 1'b0;
    end else begin
      r_stg_k   <= w_stg_k_nxt;
      r_stg_c   <= w_stg_c_nxt;
      r_const_k <= w_const_k_nxt;
      r_const_c <= w_const_c_nxt;
      r_pending <= w_pending_nxt;
      r_update  <= w_update_nxt;
    end
  end

  assign bus.oCONST_K = r_const_k;
  assign bus.oCONST_C = r_const_c;
  assign bus.oPENDING = r_pending;
  assign bus.oUPDATE  = r_update;

endmodule

// File: tb/tb_eq_param_ctrl.sv
// Bench for eq_param_ctrl: directed scenarios plus randomized key presses against a
// press-level reference model (one step per accepted press, saturating, frame commit).
module tb_eq_param_ctrl;
  localparam int unsigned DB = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RR = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eq_param_ctrl_if bus();

  eq_param_ctrl #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
    .K_RESET(8'd1), .C_RESET(8'd0)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int m_k, m_c, m_ck, m_cc;   // model: staged K/C, committed K/C

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void model_reset();
    m_k = 1; m_c = 0; m_ck = 1; m_cc = 0;
  endfunction

  function automatic void model_step(input bit dec, input bit sel, input bit en);
    if (!en) return;
    if (sel) m_c = dec ? ((m_c > 0) ? m_c - 1 : 0) : ((m_c < 255) ? m_c + 1 : 255);
    else     m_k = dec ? ((m_k > 1) ? m_k - 1 : 1) : ((m_k < 255) ? m_k + 1 : 255);
  endfunction

  function automatic int exp_pend();
    return ((m_k != m_ck) || (m_c != m_cc)) ? 1 : 0;
  endfunction

  task automatic set_key(input bit dec, input logic lvl);
    if (dec) bus.iDEC_KEY_N = lvl;
    else     bus.iINC_KEY_N = lvl;
  endtask

  // One clean press held for `hold` cycles, then released and allowed to settle.
  task automatic press(input bit dec, input bit sel, input bit en, input int hold);
    bus.iSEL_C = sel;
    bus.iEN    = en;
    set_key(dec, 1'b0);
    tick(hold);
    set_key(dec, 1'b1);
    tick(DB + 6);
    if (hold >= int'(DB) + 2) model_step(dec, sel, en);
    chk("pending_after_press", int'(bus.oPENDING), exp_pend());
  endtask

  task automatic frame();
    int exp_u;
    exp_u = exp_pend();
    bus.iFRAME_END = 1'b1;
    tick(1);
    bus.iFRAME_END = 1'b0;
    m_ck = m_k;
    m_cc = m_c;
    chk("commit_k", int'(bus.oCONST_K), m_ck);
    chk("commit_c", int'(bus.oCONST_C), m_cc);
    chk("update_pulse", int'(bus.oUPDATE), exp_u);
    chk("pending_after_commit", int'(bus.oPENDING), 0);
    tick(1);
    chk("update_single", int'(bus.oUPDATE), 0);
  endtask

  initial begin
    int kb, d;
    bus.iINC_KEY_N = 1'b1;
    bus.iDEC_KEY_N = 1'b1;
    bus.iSEL_C     = 1'b0;
    bus.iEN        = 1'b1;
    bus.iFRAME_END = 1'b0;
    rst = 1'b1;
    model_reset();
    tick(3);
    chk("rst_k", int'(bus.oCONST_K), 1);
    chk("rst_c", int'(bus.oCONST_C), 0);
    chk("rst_pending", int'(bus.oPENDING), 0);
    chk("rst_update", int'(bus.oUPDATE), 0);
    rst = 1'b0;
    tick(2);

    // Single press of INC on K
    press(1'b0, 1'b0, 1'b1, 10);
    chk("single_pending", int'(bus.oPENDING), 1);
    frame();
    chk("single_k", int'(bus.oCONST_K), 2);

    // Bounce: 2-cycle pulses never survive debounce
    for (int i = 0; i < 5; i++) begin
      bus.iINC_KEY_N = 1'b0; tick(2);
      bus.iINC_KEY_N = 1'b1; tick(2);
    end
    tick(DB + 6);
    chk("bounce_pending", int'(bus.oPENDING), 0);
    frame();

    // Saturation of K at 1 and C at 0 / 255
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 1'b1, 10);
    frame();
    chk("k_floor", int'(bus.oCONST_K), 1);
    press(1'b1, 1'b1, 1'b1, 8);
    frame();
    chk("c_floor", int'(bus.oCONST_C), 0);
    while (m_c < 255) press(1'b0, 1'b1, 1'b1, int'(DB) + 2);
    press(1'b0, 1'b1, 1'b1, 10);
    frame();
    chk("c_ceiling", int'(bus.oCONST_C), 255);

    // Disabled: steps suppressed
    press(1'b0, 1'b0, 1'b0, 10);
    chk("disabled_pending", int'(bus.oPENDING), 0);

    // Arbitration: second key during debounce cancels; then DEC alone steps 3 -> 2
    press(1'b0, 1'b0, 1'b1, 10);
    press(1'b0, 1'b0, 1'b1, 10);
    frame();
    chk("arb_k_start", int'(bus.oCONST_K), 3);
    bus.iINC_KEY_N = 1'b0;
    tick(2);
    bus.iDEC_KEY_N = 1'b0;
    tick(10);
    bus.iINC_KEY_N = 1'b1;
    bus.iDEC_KEY_N = 1'b1;
    tick(DB + 6);
    chk("arb_no_step", int'(bus.oPENDING), 0);
    press(1'b1, 1'b0, 1'b1, 10);
    frame();
    chk("arb_dec_k", int'(bus.oCONST_K), 2);

    // Randomized presses and commits
    for (int i = 0; i < 40; i++) begin
      press(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0), int'($urandom_range(DB + 2, DB + 12)));
      if ($urandom_range(0, 2) == 0) frame();
    end
    frame();

    // Step and frame end in the same cycle: old value committed, step stays pending
    bus.iSEL_C = 1'b0;
    bus.iEN    = 1'b1;
    bus.iINC_KEY_N = 1'b0;
    tick(6);
    bus.iFRAME_END = 1'b1;
    tick(1);
    bus.iFRAME_END = 1'b0;
    model_step(1'b0, 1'b0, 1'b1);
    chk("coll_k_old", int'(bus.oCONST_K), m_ck);
    chk("coll_update", int'(bus.oUPDATE), 0);
    chk("coll_pending", int'(bus.oPENDING), exp_pend());
    tick(4);
    bus.iINC_KEY_N = 1'b1;
    tick(DB + 6);
    frame();

    // Reset while HELD: defaults return and a still-held key must re-debounce
    press(1'b0, 1'b1, 1'b1, 10);
    frame();
    bus.iSEL_C = 1'b0;
    bus.iINC_KEY_N = 1'b0;
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_reset();
    chk("rst_mid_k", int'(bus.oCONST_K), 1);
    chk("rst_mid_c", int'(bus.oCONST_C), 0);
    chk("rst_mid_pending", int'(bus.oPENDING), 0);
    tick(DB);
    chk("rst_no_early_step", int'(bus.oPENDING), 0);
    tick(6);
    model_step(1'b0, 1'b0, 1'b1);
    chk("rst_fresh_step", int'(bus.oPENDING), exp_pend());
    bus.iINC_KEY_N = 1'b1;
    tick(DB + 6);
    frame();
    chk("rst_fresh_k", int'(bus.oCONST_K), 2);

    // Long hold: one step without auto-repeat, 1 + floor((60-2-4-20)/5) = 7 (+/-1) with it
    kb = int'(bus.oCONST_K);
    bus.iINC_KEY_N = 1'b0;
    tick(60);
    bus.iINC_KEY_N = 1'b1;
    tick(DB + 6);
    bus.iFRAME_END = 1'b1;
    tick(1);
    bus.iFRAME_END = 1'b0;
    d = int'(bus.oCONST_K) - kb;
`ifdef EQ_PARAM_CTRL_AUTOREPEAT_EN
    chk("repeat_steps_in_6_to_8", (d >= 6 && d <= 8) ? 1 : 0, 1);
`else
    chk("held_single_step", d, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
